// File: rtl/wb_pkg.sv
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared widths and writeback request type for the wb_arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
  } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module   : wb_fifo
// Brief    : Circular pending-write buffer with per-entry squash by rd.
//            Forwarding lookup ports exist only when WB_FWD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_enq,
  input  wb_req_t                      i_enq_req,
  input  logic                         i_deq,
  input  logic                         i_inv_en,
  input  logic [REG_IDX_W-1:0]         i_inv_rd,
  output wb_req_t                      o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
`ifdef WB_FWD_EN
  ,
  input  logic [REG_IDX_W-1:0]         i_rs_a,
  input  logic [REG_IDX_W-1:0]         i_rs_b,
  output logic                         o_hit_a,
  output logic                         o_hit_b,
  output logic [DATA_W-1:0]            o_data_a,
  output logic [DATA_W-1:0]            o_data_b
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  function automatic logic [PTR_W-1:0] wrap(input int v);
    int t;
    t = v % DEPTH;
    return t[PTR_W-1:0];
  endfunction

  wb_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0] w_phys [DEPTH];
  logic [DEPTH-1:0] w_live;
  logic             w_any;
  logic [PTR_W-1:0] w_first;
  logic [CNT_W-1:0] w_rm;

  // w_live is in logical order: index 0 is the oldest occupied slot
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_phys[i] = wrap(int'(r_head) + i);
      w_live[i] = (i < int'(r_count)) && r_mem[w_phys[i]].valid;
    end
  end

  always_comb begin
    w_any   = 1'b0;
    w_first = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_live[i]) begin
        w_any   = 1'b1;
        w_first = PTR_W'(i);
      end
    end
  end

  // Squashed slots ahead of the oldest live entry are retired in the same
  // cycle, so a squash never costs a write-port bubble.
  always_comb begin
    if (!w_any) begin
      w_rm = r_count;
    end else if (i_deq) begin
      w_rm = CNT_W'(w_first) + CNT_W'(1);
    end else begin
      w_rm = CNT_W'(w_first);
    end
  end

  always_comb begin
    o_head       = r_mem[w_phys[w_first]];
    o_head.valid = w_any;
  end

  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (i_inv_en && (r_mem[k].rd == i_inv_rd)) begin
          r_mem[k].valid <= 1'b0;
        end
      end
      if (i_enq) begin
        r_mem[r_tail] <= i_enq_req;
        r_tail        <= wrap(int'(r_tail) + 1);
      end
      r_head  <= wrap(int'(r_head) + int'(w_rm));
      r_count <= r_count - w_rm + CNT_W'(i_enq);
    end
  end

`ifdef WB_FWD_EN
  // Later logical entries overwrite earlier ones, so the youngest match wins
  always_comb begin
    o_hit_a  = 1'b0;
    o_hit_b  = 1'b0;
    o_data_a = '0;
    o_data_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_live[i] && (i_rs_a != '0) && (r_mem[w_phys[i]].rd == i_rs_a)) begin
        o_hit_a  = 1'b1;
        o_data_a = r_mem[w_phys[i]].data;
      end
      if (w_live[i] && (i_rs_b != '0) && (r_mem[w_phys[i]].rd == i_rs_b)) begin
        o_hit_b  = 1'b1;
        o_data_b = r_mem[w_phys[i]].data;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module   : wb_arbiter
// Brief    : Arbitrates ALU and multdiv writebacks onto one register-file port.
//            Define WB_FWD_EN to enable the forwarding lookup outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 ctrl_reset,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 md_valid,
  input  logic [REG_IDX_W-1:0] md_rd,
  input  logic [DATA_W-1:0]    md_data,
  output logic                 md_ready,
  output logic                 ctrl_writeEnable,
  output logic [REG_IDX_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0]    data_writeReg,
  input  logic [REG_IDX_W-1:0] fwd_rsA,
  input  logic [REG_IDX_W-1:0] fwd_rsB,
  output logic                 fwd_hitA,
  output logic                 fwd_hitB,
  output logic [DATA_W-1:0]    fwd_dataA,
  output logic [DATA_W-1:0]    fwd_dataB
);

  wb_req_t                      w_head;
  logic [$clog2(DEPTH+1)-1:0]   w_count;
  wb_req_t                      w_sel;
  logic                         w_alu_req;
  logic                         w_md_live;
  logic                         w_deq;
  logic                         w_enq;

  logic                         r_we;
  logic [REG_IDX_W-1:0]         r_wreg;
  logic [DATA_W-1:0]            r_wdata;

`ifdef WB_FWD_EN
  logic                         w_buf_hit_a;
  logic                         w_buf_hit_b;
  logic [DATA_W-1:0]            w_buf_data_a;
  logic [DATA_W-1:0]            w_buf_data_b;
`endif

  // When full, the buffer can take a new entry only if its head drains now
  assign md_ready = (int'(w_count) < DEPTH) || !alu_valid;

  // rd=0 writes are dropped; an md result older than a same-cycle ALU write to
  // the same register is stale and dropped too.
  assign w_alu_req = alu_valid && (alu_rd != '0);
  assign w_md_live = md_valid && md_ready && (md_rd != '0) &&
                     !(alu_valid && (alu_rd == md_rd));

  always_comb begin
    w_sel = '0;
    w_deq = 1'b0;
    w_enq = 1'b0;
    if (w_alu_req) begin
      w_sel = '{1'b1, alu_rd, alu_data};
      w_enq = w_md_live;
    end else if (w_head.valid) begin
      w_sel = w_head;
      w_deq = 1'b1;
      w_enq = w_md_live;
    end else if (w_md_live) begin
      w_sel = '{1'b1, md_rd, md_data};
    end
  end

  wb_fifo #(
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst       (ctrl_reset),
    .i_enq     (w_enq),
    .i_enq_req ('{1'b1, md_rd, md_data}),
    .i_deq     (w_deq),
    .i_inv_en  (w_alu_req),
    .i_inv_rd  (alu_rd),
    .o_head    (w_head),
    .o_count   (w_count)
`ifdef WB_FWD_EN
    ,
    .i_rs_a    (fwd_rsA),
    .i_rs_b    (fwd_rsB),
    .o_hit_a   (w_buf_hit_a),
    .o_hit_b   (w_buf_hit_b),
    .o_data_a  (w_buf_data_a),
    .o_data_b  (w_buf_data_b)
`endif
  );

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else begin
      r_we    <= w_sel.valid;
      r_wreg  <= w_sel.rd;
      r_wdata <= w_sel.data;
    end
  end

  assign ctrl_writeEnable = r_we;
  assign ctrl_writeReg    = r_wreg;
  assign data_writeReg    = r_wdata;

`ifdef WB_FWD_EN
  // The write-port value is youngest, so it takes priority over the buffer
  always_comb begin
    fwd_hitA  = w_buf_hit_a;
    fwd_dataA = w_buf_data_a;
    fwd_hitB  = w_buf_hit_b;
    fwd_dataB = w_buf_data_b;
    if ((fwd_rsA != '0) && r_we && (r_wreg == fwd_rsA)) begin
      fwd_hitA  = 1'b1;
      fwd_dataA = r_wdata;
    end
    if ((fwd_rsB != '0) && r_we && (r_wreg == fwd_rsB)) begin
      fwd_hitB  = 1'b1;
      fwd_dataB = r_wdata;
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_rsA, fwd_rsB};
  assign fwd_hitA  = 1'b0;
  assign fwd_hitB  = 1'b0;
  assign fwd_dataA = '0;
  assign fwd_dataB = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Directed self-checking bench for wb_arbiter (DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  fwd_rsA;
  logic [4:0]  fwd_rsB;
  logic        fwd_hitA;
  logic        fwd_hitB;
  logic [31:0] fwd_dataA;
  logic [31:0] fwd_dataB;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  wb_arbiter #(
    .DEPTH            (DEPTH)
  ) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .alu_valid        (alu_valid),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .md_valid         (md_valid),
    .md_rd            (md_rd),
    .md_data          (md_data),
    .md_ready         (md_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .fwd_rsA          (fwd_rsA),
    .fwd_rsB          (fwd_rsB),
    .fwd_hitA         (fwd_hitA),
    .fwd_hitB         (fwd_hitB),
    .fwd_dataA        (fwd_dataA),
    .fwd_dataB        (fwd_dataB)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = adat;
    md_valid  = mv;
    md_rd     = mrd;
    md_data   = mdat;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b1;
    idle();
    fwd_rsA = 5'd0;
    fwd_rsB = 5'd0;
    tick();
    tick();
    ctrl_reset = 1'b0;
    #1;
    n_checks++;
    if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_port: we=%b rd=%0d data=%h, expected 0/0/0",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    n_checks++;
    if (md_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_md_ready: got %b, expected 1", md_ready);
    end
    n_checks++;
    if (fwd_hitA !== 1'b0 || fwd_hitB !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fwd: hitA=%b hitB=%b, expected 0/0", fwd_hitA, fwd_hitB);
    end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 5'd3, 32'hAAAA_0001, 1'b1, 5'd5, 32'h5);
    #1;
    n_checks++;
    if (md_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_md_ready: got %b, expected 1", md_ready);
    end
    tick();
    idle();
    n_checks++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd3 || data_writeReg !== 32'hAAAA_0001) begin
      n_fail++;
      $display("FAIL simul_alu_write: we=%b rd=%0d data=%h, expected 1/3/aaaa0001",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    tick();
    n_checks++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd5 || data_writeReg !== 32'h5) begin
      n_fail++;
      $display("FAIL simul_md_write: we=%b rd=%0d data=%h, expected 1/5/00000005",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    tick();
    n_checks++;
    if (ctrl_writeEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_single_pulse: we=%b, expected 0", ctrl_writeEnable);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] mrd_tab [4];
    logic [4:0] exp_rd  [3];
    mrd_tab = '{5'd6, 5'd7, 5'd8, 5'd8};
    exp_rd  = '{5'd6, 5'd7, 5'd8};
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 5'(10 + c), 32'(256 + c), 1'b1, mrd_tab[c], 32'h600 | 32'(mrd_tab[c]));
      #1;
      n_checks++;
      if (md_ready !== (c < 2)) begin
        n_fail++;
        $display("FAIL bp_md_ready[%0d]: got %b, expected %b", c, md_ready, (c < 2));
      end
      tick();
      n_checks++;
      if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'(10 + c) || data_writeReg !== 32'(256 + c)) begin
        n_fail++;
        $display("FAIL bp_alu_write[%0d]: we=%b rd=%0d data=%h, expected 1/%0d/%h",
                 c, ctrl_writeEnable, ctrl_writeReg, data_writeReg, 10 + c, 256 + c);
      end
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h608);
    #1;
    n_checks++;
    if (md_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full_drain_ready: got %b, expected 1", md_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      idle();
      n_checks++;
      if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== exp_rd[k] ||
          data_writeReg !== (32'h600 | 32'(exp_rd[k]))) begin
        n_fail++;
        $display("FAIL bp_drain[%0d]: we=%b rd=%0d data=%h, expected 1/%0d/%h",
                 k, ctrl_writeEnable, ctrl_writeReg, data_writeReg, exp_rd[k],
                 32'h600 | 32'(exp_rd[k]));
      end
    end
    tick();
    n_checks++;
    if (ctrl_writeEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_after_drain: we=%b, expected 0", ctrl_writeEnable);
    end
  endtask

  task automatic test_squash();
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h9999);
    tick();
    drive(1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 32'd0);
    tick();
    idle();
    n_checks++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd9 || data_writeReg !== 32'h1234) begin
      n_fail++;
      $display("FAIL squash_alu_write: we=%b rd=%0d data=%h, expected 1/9/00001234",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (ctrl_writeEnable !== 1'b0) begin
        n_fail++;
        $display("FAIL squash_no_md_write[%0d]: we=%b rd=%0d data=%h, expected we=0",
                 k, ctrl_writeEnable, ctrl_writeReg, data_writeReg);
      end
    end
  endtask

  task automatic test_r0_discard();
    drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h77);
    tick();
    idle();
    n_checks++;
    if (ctrl_writeEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_no_write: we=%b, expected 0", ctrl_writeEnable);
    end
    tick();
    n_checks++;
    if (ctrl_writeEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_buffer_empty: we=%b rd=%0d, expected we=0", ctrl_writeEnable, ctrl_writeReg);
    end
    // A lone md request must bypass straight to the port if nothing is buffered
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'hF);
    tick();
    idle();
    n_checks++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd15 || data_writeReg !== 32'hF) begin
      n_fail++;
      $display("FAIL bypass_write: we=%b rd=%0d data=%h, expected 1/15/0000000f",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    tick();
  endtask

  task automatic test_reset_flush();
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd20, 32'h20);
    tick();
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd21, 32'h21);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd22, 32'h2222);
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    idle();
    #1;
    n_checks++;
    if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0 ||
        md_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_outputs: we=%b rd=%0d data=%h rdy=%b, expected 0/0/0/1",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (ctrl_writeEnable !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_no_write[%0d]: we=%b rd=%0d, expected we=0",
                 k, ctrl_writeEnable, ctrl_writeReg);
      end
    end
  endtask

  task automatic test_forwarding();
    logic        exp_en;
`ifdef WB_FWD_EN
    exp_en = 1'b1;
`else
    exp_en = 1'b0;
`endif
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 32'hBEEF);
    tick();
    idle();
    fwd_rsA = 5'd4;
    fwd_rsB = 5'd0;
    #1;
    n_checks++;
    if (fwd_hitA !== exp_en || fwd_dataA !== (exp_en ? 32'hBEEF : 32'd0)) begin
      n_fail++;
      $display("FAIL fwd_buffer_A: hit=%b data=%h, expected %b/%h",
               fwd_hitA, fwd_dataA, exp_en, exp_en ? 32'hBEEF : 32'd0);
    end
    n_checks++;
    if (fwd_hitB !== 1'b0 || fwd_dataB !== 32'd0) begin
      n_fail++;
      $display("FAIL fwd_r0_B: hit=%b data=%h, expected 0/0", fwd_hitB, fwd_dataB);
    end
    fwd_rsB = 5'd1;
    #1;
    n_checks++;
    if (fwd_hitB !== exp_en || fwd_dataB !== (exp_en ? 32'h1 : 32'd0)) begin
      n_fail++;
      $display("FAIL fwd_port_B: hit=%b data=%h, expected %b/%h",
               fwd_hitB, fwd_dataB, exp_en, exp_en ? 32'h1 : 32'd0);
    end
    tick();
    n_checks++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd4 || fwd_hitA !== exp_en ||
        fwd_dataA !== (exp_en ? 32'hBEEF : 32'd0) || fwd_hitB !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_after_drain: we=%b rd=%0d hitA=%b dataA=%h hitB=%b, expected 1/4/%b/%h/0",
               ctrl_writeEnable, ctrl_writeReg, fwd_hitA, fwd_dataA, fwd_hitB,
               exp_en, exp_en ? 32'hBEEF : 32'd0);
    end
    fwd_rsA = 5'd0;
    fwd_rsB = 5'd0;
    tick();
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_backpressure();
    test_squash();
    test_r0_discard();
    test_reset_flush();
    test_forwarding();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
